// File: rtl/multi_pipe_collision_tracker_pkg.sv
// Shared types and default geometry for the flappy-bird collision tracker.
package collision_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    localparam int DEF_COORD_W     = 10;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_BIRD_HALF_W = 8;
    localparam int DEF_BIRD_HALF_H = 8;
    localparam int DEF_PIPE_HALF_W = 20;
    localparam int DEF_GAP_HALF    = 60;
endpackage

// File: rtl/multi_pipe_collision_tracker_if.sv
// Frame-tick request side and result side of the collision tracker.
interface multi_pipe_collision_tracker_if #(
    parameter int NUM_PIPES = 4,
    parameter int COORD_W   = 10
);
    logic                          start;
    logic                          clear;
    logic [COORD_W-1:0]            bird_x;
    logic [COORD_W-1:0]            bird_y;
    logic [NUM_PIPES-1:0]          pipe_valid;
    logic [NUM_PIPES*COORD_W-1:0]  pipe_x;
    logic [NUM_PIPES*COORD_W-1:0]  pipe_gap_y;
    logic                          busy;
    logic                          done;
    logic [NUM_PIPES-1:0]          hit_mask;
    logic                          bound_hit;
    logic                          collision;

    modport master (
        output start, clear, bird_x, bird_y, pipe_valid, pipe_x, pipe_gap_y,
        input  busy, done, hit_mask, bound_hit, collision
    );
    modport slave (
        input  start, clear, bird_x, bird_y, pipe_valid, pipe_x, pipe_gap_y,
        output busy, done, hit_mask, bound_hit, collision
    );
endinterface

// File: rtl/multi_pipe_collision_tracker_pipe_hit_check.sv
// Single-channel bird-vs-pipe test; add-only compares in COORD_W+2 bits.
module pipe_hit_check
    import collision_pkg::*;
#(
    parameter int COORD_W     = DEF_COORD_W,
    parameter int BIRD_HALF_W = DEF_BIRD_HALF_W,
    parameter int BIRD_HALF_H = DEF_BIRD_HALF_H,
    parameter int PIPE_HALF_W = DEF_PIPE_HALF_W,
    parameter int GAP_HALF    = DEF_GAP_HALF
) (
    input  logic [COORD_W-1:0] bird_x_i,
    input  logic [COORD_W-1:0] bird_y_i,
    input  logic [COORD_W-1:0] pipe_x_i,
    input  logic [COORD_W-1:0] gap_y_i,
    input  logic               valid_i,
    output logic               hit_o
);
    localparam int AW = COORD_W + 2;
    localparam logic [AW-1:0] XR = AW'(BIRD_HALF_W + PIPE_HALF_W);
    localparam logic [AW-1:0] GH = AW'(GAP_HALF);
    localparam logic [AW-1:0] BH = AW'(BIRD_HALF_H);

    logic [AW-1:0] bx, by, px, gy;
    logic          x_ov, in_gap;

    assign bx = AW'(bird_x_i);
    assign by = AW'(bird_y_i);
    assign px = AW'(pipe_x_i);
    assign gy = AW'(gap_y_i);

    // strict > on x: touching edges do not overlap; >=/<= on y: flush with gap is safe
    assign x_ov   = (bx + XR > px) && (px + XR > bx);
    assign in_gap = (by + GH >= gy + BH) && (by + BH <= gy + GH);
    assign hit_o  = valid_i && x_ov && !in_gap;
endmodule

// File: rtl/multi_pipe_collision_tracker.sv
// Per-frame collision engine: snapshot at start, one pipe per clock, sticky collision.
module multi_pipe_collision_tracker
    import collision_pkg::*;
#(
    parameter int NUM_PIPES   = 4,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int BIRD_HALF_W = DEF_BIRD_HALF_W,
    parameter int BIRD_HALF_H = DEF_BIRD_HALF_H,
    parameter int PIPE_HALF_W = DEF_PIPE_HALF_W,
    parameter int GAP_HALF    = DEF_GAP_HALF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    multi_pipe_collision_tracker_if.slave  bus
);
    localparam int AW    = COORD_W + 2;
    localparam int IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

    typedef struct packed {
        logic [COORD_W-1:0]                bx;
        logic [COORD_W-1:0]                by;
        logic [NUM_PIPES-1:0]              vld;
        logic [NUM_PIPES-1:0][COORD_W-1:0] px;
        logic [NUM_PIPES-1:0][COORD_W-1:0] gy;
    } snap_t;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    snap_t                snap_q, snap_d, snap_live;
    logic [NUM_PIPES-1:0] mask_q, mask_d, hit_mask_q, hit_mask_d;
    logic                 bound_q, bound_d, bound_hit_q, bound_hit_d;
    logic                 done_q, done_d, coll_q, coll_d;
    logic                 hit, bound_w;
    logic [AW-1:0]        by_ext;

    always_comb begin
        snap_live.bx  = bus.bird_x;
        snap_live.by  = bus.bird_y;
        snap_live.vld = bus.pipe_valid;
        snap_live.px  = bus.pipe_x;
        snap_live.gy  = bus.pipe_gap_y;
    end

    pipe_hit_check #(
        .COORD_W(COORD_W), .BIRD_HALF_W(BIRD_HALF_W), .BIRD_HALF_H(BIRD_HALF_H),
        .PIPE_HALF_W(PIPE_HALF_W), .GAP_HALF(GAP_HALF)
    ) u_chk (
        .bird_x_i(snap_q.bx), .bird_y_i(snap_q.by),
        .pipe_x_i(snap_q.px[idx_q]), .gap_y_i(snap_q.gy[idx_q]),
        .valid_i(snap_q.vld[idx_q]), .hit_o(hit)
    );

    assign by_ext  = AW'(snap_q.by);
    assign bound_w = (by_ext < AW'(BIRD_HALF_H)) ||
                     (by_ext + AW'(BIRD_HALF_H) >= AW'(SCREEN_H));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        mask_d      = mask_q;
        bound_d     = bound_q;
        hit_mask_d  = hit_mask_q;
        bound_hit_d = bound_hit_q;
        coll_d      = coll_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                snap_d  = snap_live;
                idx_d   = '0;
                mask_d  = '0;
                state_d = SCAN;
            end
            SCAN: begin
                mask_d[idx_q] = hit;
                if (idx_q == '0) bound_d = bound_w;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(NUM_PIPES - 1)) state_d = DONE;
            end
            DONE: begin
                hit_mask_d  = mask_q;
                bound_hit_d = bound_q;
                done_d      = 1'b1;
                coll_d      = coll_q | (|mask_q) | bound_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // clear wins over everything, including a same-cycle start
        if (bus.clear) begin
            state_d     = IDLE;
            hit_mask_d  = '0;
            bound_hit_d = 1'b0;
            coll_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            snap_q      <= '0;
            mask_q      <= '0;
            bound_q     <= 1'b0;
            hit_mask_q  <= '0;
            bound_hit_q <= 1'b0;
            done_q      <= 1'b0;
            coll_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            mask_q      <= mask_d;
            bound_q     <= bound_d;
            hit_mask_q  <= hit_mask_d;
            bound_hit_q <= bound_hit_d;
            done_q      <= done_d;
            coll_q      <= coll_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.hit_mask  = hit_mask_q;
    assign bus.bound_hit = bound_hit_q;
    assign bus.collision = coll_q;
endmodule

// File: tb/tb_multi_pipe_collision_tracker.sv
// Directed bench for the collision tracker with a cycle-level reference model.
module tb_multi_pipe_collision_tracker;
    localparam int NP = 4;
    localparam int CW = 10;

    logic clk, rst_n;
    int   vectors = 0;
    int   errs    = 0;

    multi_pipe_collision_tracker_if #(.NUM_PIPES(NP), .COORD_W(CW)) bus ();
    multi_pipe_collision_tracker #(.NUM_PIPES(NP), .COORD_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-frame result from geometry: {bound, mask}
    function automatic logic [NP:0] frame_result();
        logic [NP:0] r;
        int bx, by, px, gy, dx;
        r  = '0;
        bx = int'(bus.bird_x);
        by = int'(bus.bird_y);
        r[NP] = (by < 8) || (by > 471);
        for (int i = 0; i < NP; i++) begin
            px = int'(bus.pipe_x[i*CW +: CW]);
            gy = int'(bus.pipe_gap_y[i*CW +: CW]);
            dx = bx - px;
            r[i] = bus.pipe_valid[i] && (dx < 28) && (dx > -28) &&
                   !((by >= gy - 52) && (by <= gy + 52));
        end
        return r;
    endfunction

    // Reference: result lands NP+1 edges after the accepted start
    int          m_cnt;
    logic [NP:0] m_pend;
    logic [NP-1:0] m_mask;
    logic        m_bound, m_coll, m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_pend <= '0; m_mask <= '0;
            m_bound <= 1'b0; m_coll <= 1'b0; m_done <= 1'b0;
        end else if (bus.clear) begin
            m_cnt <= 0; m_mask <= '0; m_bound <= 1'b0; m_coll <= 1'b0; m_done <= 1'b0;
        end else if (m_cnt == 0) begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_cnt  <= NP + 1;
                m_pend <= frame_result();
            end
        end else if (m_cnt == 1) begin
            m_cnt   <= 0;
            m_mask  <= m_pend[NP-1:0];
            m_bound <= m_pend[NP];
            m_coll  <= m_coll | (|m_pend);
            m_done  <= 1'b1;
        end else begin
            m_cnt  <= m_cnt - 1;
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_cnt != 0));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("hit_mask", 32'(bus.hit_mask), 32'(m_mask));
        chk("bound_hit", 32'(bus.bound_hit), 32'(m_bound));
        chk("collision", 32'(bus.collision), 32'(m_coll));
    end

    task automatic set_pipe(input int i, input bit v, input int x, input int g);
        bus.pipe_valid[i]          = v;
        bus.pipe_x[i*CW +: CW]     = CW'(x);
        bus.pipe_gap_y[i*CW +: CW] = CW'(g);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then count edges until done; returns latency
    task automatic run_scan(output int lat);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            lat++;
            #2;
            if (bus.done) break;
        end
        if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
        #1;
    endtask

    int lat, dones;

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.clear = 1'b0;
        bus.bird_x = CW'(100); bus.bird_y = CW'(240);
        bus.pipe_valid = '0; bus.pipe_x = '0; bus.pipe_gap_y = '0;
        repeat (2) step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_coll", 32'(bus.collision), 32'd0);
        rst_n = 1'b1;
        step();

        // bird inside gap: no hit, latency NP+1
        set_pipe(0, 1, 100, 240);
        run_scan(lat);
        chk("latency", 32'(lat), 32'd5);
        chk("pass_mask", 32'(bus.hit_mask), 32'h0);
        chk("pass_coll", 32'(bus.collision), 32'd0);

        set_pipe(0, 1, 100, 150);
        run_scan(lat);
        chk("hit_mask0", 32'(bus.hit_mask), 32'h1);
        chk("hit_coll", 32'(bus.collision), 32'd1);

        set_pipe(0, 0, 100, 150);
        run_scan(lat);
        chk("sticky_mask", 32'(bus.hit_mask), 32'h0);
        chk("sticky_coll", 32'(bus.collision), 32'd1);
        bus.clear = 1'b1; step(); bus.clear = 1'b0;
        chk("clear_coll", 32'(bus.collision), 32'd0);

        // ceiling / floor boundaries
        bus.bird_y = CW'(4);   run_scan(lat); chk("ceiling", 32'(bus.bound_hit), 32'd1);
        bus.bird_y = CW'(472); run_scan(lat); chk("floor472", 32'(bus.bound_hit), 32'd1);
        bus.bird_y = CW'(471); run_scan(lat); chk("floor471", 32'(bus.bound_hit), 32'd0);

        // x edge touching vs one-pixel overlap
        bus.bird_y = CW'(240);
        set_pipe(2, 1, 128, 0); run_scan(lat); chk("x128", 32'(bus.hit_mask), 32'h0);
        set_pipe(2, 1, 127, 0); run_scan(lat); chk("x127", 32'(bus.hit_mask), 32'h4);

        // gap flush edge counts as safe; one pixel beyond hits
        set_pipe(2, 0, 0, 0);
        set_pipe(1, 1, 100, 240);
        bus.bird_y = CW'(188); run_scan(lat); chk("gap_flush", 32'(bus.hit_mask), 32'h0);
        bus.bird_y = CW'(187); run_scan(lat); chk("gap_out", 32'(bus.hit_mask), 32'h2);

        // extra start while busy and inputs changed mid-scan
        bus.bird_y = CW'(240);
        set_pipe(1, 0, 0, 0);
        set_pipe(3, 1, 110, 0);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        step();
        bus.start = 1'b1; set_pipe(3, 0, 600, 240); bus.bird_y = CW'(2);
        step();
        bus.start = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #2;
            if (bus.done) dones++;
            if (bus.done) chk("snap_mask", 32'(bus.hit_mask), 32'h8);
            if (bus.done) chk("snap_bound", 32'(bus.bound_hit), 32'd0);
        end
        chk("one_done", 32'(dones), 32'd1);
        #1;

        // clear together with start at scan cycle 2 aborts
        set_pipe(3, 1, 110, 0); bus.bird_y = CW'(240);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        step();
        bus.clear = 1'b1; bus.start = 1'b1;
        @(posedge clk); #2;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        #1;
        bus.clear = 1'b0; bus.start = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #2;
            if (bus.done) dones++;
        end
        chk("abort_nodone", 32'(dones), 32'd0);
        chk("abort_coll", 32'(bus.collision), 32'd0);
        #1;

        // async reset mid-scan after a hit has made outputs nonzero
        run_scan(lat);
        chk("pre_rst_coll", 32'(bus.collision), 32'd1);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_mask", 32'(bus.hit_mask), 32'h0);
        chk("arst_coll", 32'(bus.collision), 32'd0);
        #1 rst_n = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/multi_pipe_collision_tracker.md
Name: multi_pipe_collision_tracker

Overview:
Per-frame collision engine for the flappy-bird game core. Checks the bird box against NUM_PIPES pipe channels and against the screen ceiling and floor. Pipes are scanned sequentially, one per clock, from a snapshot taken at the frame tick. Produces a per-frame hit mask and a sticky game-over collision flag consumed by the game FSM.

Parameters:
NUM_PIPES, 4, number of pipe channels scanned per frame (1..16)
COORD_W, 10, width of every coordinate and size
SCREEN_H, 480, visible height in pixels; floor boundary
BIRD_HALF_W, 8, bird half-width
BIRD_HALF_H, 8, bird half-height
PIPE_HALF_W, 20, pipe half-width
GAP_HALF, 60, half-height of a pipe's open gap

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  frame tick; starts a scan when idle
clear  in  1  clears sticky collision and aborts any scan
bird_x  in  COORD_W  bird centre x
bird_y  in  COORD_W  bird centre y
pipe_valid  in  NUM_PIPES  channel i is on screen
pipe_x  in  NUM_PIPES*COORD_W  packed pipe centre x; channel i at [i*COORD_W +: COORD_W]
pipe_gap_y  in  NUM_PIPES*COORD_W  packed gap centre y; same packing
busy  out  1  scan in progress
done  out  1  one-cycle pulse when results update
hit_mask  out  NUM_PIPES  pipes hit in the last completed scan
bound_hit  out  1  ceiling or floor hit in the last completed scan
collision  out  1  sticky: any hit since the last clear or reset

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, hit_mask, bound_hit and collision are all 0; snapshot registers are 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE, start=1, clear=0 at edge T:
  - snapshot bird_x, bird_y, pipe_valid, pipe_x and pipe_gap_y.
  - idx=0, state=SCAN, busy=1.
  - clear the working mask.
- Bounds check, evaluated on the snapshot: bound = (bird_y < BIRD_HALF_H) or (bird_y + BIRD_HALF_H >= SCREEN_H). It is registered into the working state at the first SCAN edge.
- SCAN: each cycle evaluates channel idx on the snapshot; working mask bit idx = valid[idx] and x_overlap and not in_gap.
  - idx increments on each SCAN edge.
  - After idx=NUM_PIPES-1, state=DONE.
  - The evaluation for channel i completes at edge T+1+i.
- DONE (entered at edge T+NUM_PIPES):
  - at edge T+NUM_PIPES+1: hit_mask, bound_hit and done=1 are registered.
  - collision |= (|mask or bound).
  - state=IDLE, busy=0.
  - done is high for exactly one cycle.
- Total latency from the start edge to the done pulse is NUM_PIPES+1 cycles. busy is high for NUM_PIPES+1 cycles.
- start while busy is ignored; no queuing.
- Arithmetic is add-only, in COORD_W+2 bits, so no subtraction ever underflows:
  - x_overlap = (bird_x + BIRD_HALF_W + PIPE_HALF_W > pipe_x) and (pipe_x + PIPE_HALF_W + BIRD_HALF_W > bird_x).
  - in_gap = (bird_y + GAP_HALF >= gap_y + BIRD_HALF_H) and (bird_y + BIRD_HALF_H <= gap_y + GAP_HALF).
  - Edge-touching exactly at the x boundary is not overlap. The bird box flush with a gap edge counts as in the gap.
- clear has priority over start, in any state:
  - collision=0, hit_mask=0, bound_hit=0, done=0.
  - state=IDLE, busy=0.
  - A start in the same cycle is dropped.
- Inputs that change mid-scan have no effect; only the snapshot is used.
- Invalid channels (pipe_valid=0) never hit, whatever their coordinates.
- hit_mask and bound_hit hold between scans. collision holds until clear or reset.

Decomposition:
- Package collision_pkg:
  - state enum (IDLE, SCAN, DONE).
  - default geometry constants (SCREEN_H, BIRD_HALF_*, PIPE_HALF_W, GAP_HALF).
  - COORD_W default.
- Sub-module pipe_hit_check: purely combinational single-channel test. Inputs are the bird x/y, pipe x, gap y and valid; output is hit. One instance is muxed by idx.
- Bounds check and FSM live in the top module.

Test Plan:
- Bird (100,240); pipe0 valid at x=100, gap_y=240; other channels invalid; start -> done at start+5 (NUM_PIPES=4), hit_mask=0000, bound_hit=0, collision=0.
- Same setup, gap_y=150 -> hit_mask=0001, collision=1. A later scan with no hit -> hit_mask=0000 but collision stays 1 until clear; clear -> collision=0.
- Bird (100,4): ceiling hit -> bound_hit=1. Bird y=472: 472+8>=480 -> bound_hit=1. Bird y=471 -> bound_hit=0. Pipe x=128: 100+28>128 is false -> no hit. Pipe x=127 -> hit on pipe2 (gap_y=0) only.
- start issued while busy, and pipe inputs changed mid-scan -> the extra start is ignored, results reflect the snapshot, and exactly one done pulse occurs.
- clear asserted at scan cycle 2 together with start -> busy drops next edge, no done pulse, all outputs 0. rst_n pulsed low mid-scan -> outputs 0 immediately, asynchronously.
